mlp_job_sequencer: RTL and testbench

Sequences one MLP inference job on mlp_top, replacing raw per-signal driving by the UART controller.
- Flow: reset the weight FIFOs, stream weight bytes into column 0 and then column 1, push the initial activations, assert weights_ready, pulse start_mlp, wait for mlp_state to reach DONE, then return acc0 through a valid/ready result port.
- Placement: sits between the UART controller (job/stream side) and mlp_top (MLP side); a watchdog bounds the RUN phase.

---
 rtl/tpu_seq_pkg.sv | 24 ++
 rtl/seq_watchdog.sv | 34 +++
 rtl/mlp_job_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_mlp_job_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the MLP job sequencer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD0  = 3'd2,
    LOAD1  = 3'd3,
    ACT    = 3'd4,
    ARM    = 3'd5,
    RUN    = 3'd6,
    RESULT = 3'd7
  } seq_state_e;

  localparam logic [3:0] MLP_STATE_IDLE      = 4'd0;
  localparam logic [3:0] MLP_DONE_STATE_DFLT = 4'd8;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// RUN-phase watchdog: counts enabled cycles and flags the last allowed one.
module seq_watchdog
  import tpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  // Terminal count asserts during the TIMEOUT_CYCLES-th enabled cycle.
  assign tc_c = enable && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mlp_job_sequencer.sv
// Sequences one MLP inference job: FIFO clear, weight/activation load,
// start, wait for DONE (watchdog bounded), return acc0 via valid/ready.
// Optional build macro SEQ_PERF_CNT_EN adds the run_cycles output.
module mlp_job_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned N_WT_PER_COL   = 2,
  parameter int unsigned N_ACT          = 2,
  parameter logic [3:0]  MLP_DONE_STATE = MLP_DONE_STATE_DFLT,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_start,
  output logic               busy,
  input  logic               wt_valid,
  output logic               wt_ready,
  input  logic [7:0]         wt_data,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [15:0]        act_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [31:0] res_data,
  output logic               res_timeout,
  output logic               wf_push_col0,
  output logic               wf_push_col1,
  output logic [7:0]         wf_data_in,
  output logic               wf_reset,
  output logic               init_act_valid,
  output logic [15:0]        init_act_data,
  output logic               start_mlp,
  output logic               weights_ready,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]        run_cycles,
`endif
  input  logic [3:0]         mlp_state,
  input  logic signed [31:0] mlp_acc0
);

  localparam int unsigned N_MAX = (N_WT_PER_COL > N_ACT) ? N_WT_PER_COL : N_ACT;
  localparam int unsigned CW    = cnt_width(N_MAX);

  seq_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, wt_ready_q, wt_ready_d, act_ready_q, act_ready_d;
  logic res_valid_q, res_valid_d, res_timeout_q, res_timeout_d;
  logic signed [31:0] res_data_q, res_data_d;
  logic push0_q, push0_d, push1_q, push1_d, wf_reset_q, wf_reset_d;
  logic [7:0] wf_data_q, wf_data_d;
  logic act_valid_q, act_valid_d;
  logic [15:0] act_data_q, act_data_d;
  logic start_q, start_d, wready_q, wready_d;
  logic wd_clear, wd_en, wd_tc;
  logic wt_acc, act_acc;

  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .tc_c   (wd_tc)
  );

  assign wt_acc  = wt_valid & wt_ready_q;
  assign act_acc = act_valid & act_ready_q;

  // Next-state and next-output logic; outputs derive from the next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    push0_d       = 1'b0;
    push1_d       = 1'b0;
    wf_data_d     = wf_data_q;
    act_valid_d   = 1'b0;
    act_data_d    = act_data_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    wd_clear      = 1'b0;
    wd_en         = 1'b0;
    case (state_q)
      IDLE: if (job_start) state_d = CLR;
      CLR: begin
        cnt_d   = '0;
        state_d = LOAD0;
      end
      LOAD0, LOAD1: begin
        if (wt_acc) begin
          push0_d   = (state_q == LOAD0);
          push1_d   = (state_q == LOAD1);
          wf_data_d = wt_data;
          if (cnt_q == CW'(N_WT_PER_COL - 1)) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD0) ? LOAD1 : ACT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ACT: begin
        if (act_acc) begin
          act_valid_d = 1'b1;
          act_data_d  = act_data;
          if (cnt_q == CW'(N_ACT - 1)) begin
            cnt_d   = '0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ARM: begin
        wd_clear = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        wd_en = 1'b1;
        if (mlp_state == MLP_DONE_STATE) begin
          res_data_d    = mlp_acc0;
          res_timeout_d = 1'b0;
          state_d       = RESULT;
        end else if (wd_tc) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = RESULT;
        end
      end
      RESULT: if (res_valid_q && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wf_reset_d  = (state_d == CLR);
    busy_d      = (state_d != IDLE);
    wt_ready_d  = (state_d == LOAD0) || (state_d == LOAD1);
    act_ready_d = (state_d == ACT);
    wready_d    = (state_d == ARM) || (state_d == RUN) || (state_d == RESULT);
    res_valid_d = (state_d == RESULT);
    start_d     = (state_q == ARM);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      wt_ready_q    <= 1'b0;
      act_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_data_q    <= '0;
      push0_q       <= 1'b0;
      push1_q       <= 1'b0;
      wf_reset_q    <= 1'b0;
      wf_data_q     <= '0;
      act_valid_q   <= 1'b0;
      act_data_q    <= '0;
      start_q       <= 1'b0;
      wready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      wt_ready_q    <= wt_ready_d;
      act_ready_q   <= act_ready_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      res_data_q    <= res_data_d;
      push0_q       <= push0_d;
      push1_q       <= push1_d;
      wf_reset_q    <= wf_reset_d;
      wf_data_q     <= wf_data_d;
      act_valid_q   <= act_valid_d;
      act_data_q    <= act_data_d;
      start_q       <= start_d;
      wready_q      <= wready_d;
    end
  end

  assign busy           = busy_q;
  assign wt_ready       = wt_ready_q;
  assign act_ready      = act_ready_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_timeout    = res_timeout_q;
  assign wf_push_col0   = push0_q;
  assign wf_push_col1   = push1_q;
  assign wf_data_in     = wf_data_q;
  assign wf_reset       = wf_reset_q;
  assign init_act_valid = act_valid_q;
  assign init_act_data  = act_data_q;
  assign start_mlp      = start_q;
  assign weights_ready  = wready_q;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] rc_q, rc_d, run_cycles_q, run_cycles_d;

  // Saturating RUN-cycle count, published when RUN is left.
  always_comb begin
    rc_d         = rc_q;
    run_cycles_d = run_cycles_q;
    if (state_q == ARM) begin
      rc_d = '0;
    end else if (state_q == RUN) begin
      rc_d = (rc_q == 16'hFFFF) ? rc_q : rc_q + 16'd1;
      if (state_d != RUN) run_cycles_d = rc_d;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_q         <= '0;
      run_cycles_q <= '0;
    end else begin
      rc_q         <= rc_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_mlp_job_sequencer.sv
// Directed bench for mlp_job_sequencer (TIMEOUT_CYCLES = 16).
module tb_mlp_job_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_start = 1'b0;
  logic busy;
  logic wt_valid = 1'b0, wt_ready;
  logic [7:0] wt_data = '0;
  logic act_valid = 1'b0, act_ready;
  logic [15:0] act_data = '0;
  logic res_valid, res_ready = 1'b0;
  logic signed [31:0] res_data;
  logic res_timeout;
  logic wf_push_col0, wf_push_col1, wf_reset;
  logic [7:0] wf_data_in;
  logic init_act_valid;
  logic [15:0] init_act_data;
  logic start_mlp, weights_ready;
  logic [3:0] mlp_state = 4'd0;
  logic signed [31:0] mlp_acc0 = '0;

  int n_cmp = 0;
  int n_err = 0;

  int n_wfr, n_p0, n_p1, n_act, n_start;
  logic [7:0]  d0 [4];
  logic [7:0]  d1 [4];
  logic [15:0] da [4];

  always #5 clk = ~clk;

  mlp_job_sequencer #(
    .N_WT_PER_COL   (2),
    .N_ACT          (2),
    .MLP_DONE_STATE (4'd8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .job_start      (job_start),
    .busy           (busy),
    .wt_valid       (wt_valid),
    .wt_ready       (wt_ready),
    .wt_data        (wt_data),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .act_data       (act_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_timeout    (res_timeout),
    .wf_push_col0   (wf_push_col0),
    .wf_push_col1   (wf_push_col1),
    .wf_data_in     (wf_data_in),
    .wf_reset       (wf_reset),
    .init_act_valid (init_act_valid),
    .init_act_data  (init_act_data),
    .start_mlp      (start_mlp),
    .weights_ready  (weights_ready),
    .mlp_state      (mlp_state),
    .mlp_acc0       (mlp_acc0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wf_reset) n_wfr++;
    if (wf_push_col0) begin if (n_p0 < 4) d0[n_p0] = wf_data_in; n_p0++; end
    if (wf_push_col1) begin if (n_p1 < 4) d1[n_p1] = wf_data_in; n_p1++; end
    if (init_act_valid) begin if (n_act < 4) da[n_act] = init_act_data; n_act++; end
    if (start_mlp) n_start++;
  end

  task automatic clear_mon();
    n_wfr = 0; n_p0 = 0; n_p1 = 0; n_act = 0; n_start = 0;
    for (int i = 0; i < 4; i++) begin d0[i] = '0; d1[i] = '0; da[i] = '0; end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_wt(input logic [7:0] b);
    int t = 0;
    wt_data = b; wt_valid = 1'b1;
    while (!wt_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("wt_ready_wait", 32'(wt_ready), 1);
    @(negedge clk);
    wt_valid = 1'b0;
  endtask

  task automatic send_act(input logic [15:0] w);
    int t = 0;
    act_data = w; act_valid = 1'b1;
    while (!act_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("act_ready_wait", 32'(act_ready), 1);
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  // Full job; done_at = cycles after start_mlp before DONE is shown (-1: never).
  task automatic run_job(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input bit stall, input int done_at,
                         input logic [31:0] acc, input int hold,
                         output int lat, output logic [31:0] rdata, output logic rto);
    logic [7:0] wb [4];
    bit stable;
    int t;
    wb[0] = w0; wb[1] = w1; wb[2] = w2; wb[3] = w3;
    clear_mon();
    job_start = 1'b1; @(negedge clk); job_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (stall && i > 0) begin wt_valid = 1'b0; @(negedge clk); end
      send_wt(wb[i]);
    end
    send_act(a0);
    send_act(a1);
    t = 0;
    while (!start_mlp && t < 50) begin @(negedge clk); t++; end
    chk("start_seen", 32'(start_mlp), 1);
    chk("wready_at_start", 32'(weights_ready), 1);
    lat = 0;
    while (!res_valid && lat < 60) begin
      if (lat == done_at) begin mlp_state = 4'd8; mlp_acc0 = acc; end
      else mlp_state = 4'd0;
      @(negedge clk);
      lat++;
    end
    mlp_state = 4'd0;
    chk("res_valid_seen", 32'(res_valid), 1);
    rdata = res_data; rto = res_timeout; stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== rdata || res_timeout !== rto) stable = 1'b0;
    end
    if (hold > 0) chk("res_stable", 32'(stable), 1);
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    chk("res_valid_drop", 32'(res_valid), 0);
    chk("wready_drop", 32'(weights_ready), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("n_wf_reset", n_wfr, 1);
    chk("n_push0", n_p0, 2);
    chk("n_push1", n_p1, 2);
    chk("push0_d0", 32'(d0[0]), 32'(w0));
    chk("push0_d1", 32'(d0[1]), 32'(w1));
    chk("push1_d0", 32'(d1[0]), 32'(w2));
    chk("push1_d1", 32'(d1[1]), 32'(w3));
    chk("n_act", n_act, 2);
    chk("act_d0", 32'(da[0]), 32'(a0));
    chk("act_d1", 32'(da[1]), 32'(a1));
    chk("n_start", n_start, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd;
    logic rto;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wt_ready", 32'(wt_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_weights_ready", 32'(weights_ready), 0);
    chk("rst_start", 32'(start_mlp), 0);
    chk("rst_wf_reset", 32'(wf_reset), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal job: DONE right after start.
    run_job(8'h01, 8'h02, 8'h03, 8'h04, 16'h0010, 16'h0020, 1'b0, 0, 32'sd123, 0, lat, rd, rto);
    chk("nom_lat", lat, 1);
    chk("nom_data", rd, 123);
    chk("nom_timeout", 32'(rto), 0);

    // Backpressure: stalled weights, result held 10 cycles.
    run_job(8'hA5, 8'h5A, 8'hFF, 8'h00, 16'hBEEF, 16'h1234, 1'b1, 3, -32'sd7, 10, lat, rd, rto);
    chk("bp_lat", lat, 4);
    chk("bp_data", rd, 32'hFFFF_FFF9);
    chk("bp_timeout", 32'(rto), 0);

    // Timeout: DONE never arrives.
    run_job(8'h11, 8'h22, 8'h33, 8'h44, 16'h0001, 16'h0002, 1'b0, -1, 32'h5555_5555, 0, lat, rd, rto);
    chk("to_lat", lat, 16);
    chk("to_data", rd, 0);
    chk("to_timeout", 32'(rto), 1);

    // DONE coincides with the terminal watchdog cycle.
    run_job(8'h10, 8'h20, 8'h30, 8'h40, 16'h0100, 16'h0200, 1'b0, 15, 32'hDEAD_BEEF, 0, lat, rd, rto);
    chk("co_lat", lat, 16);
    chk("co_data", rd, 32'hDEAD_BEEF);
    chk("co_timeout", 32'(rto), 0);

    // Extra start during LOAD1, then reset during ACT.
    clear_mon();
    job_start = 1'b1; @(negedge clk); job_start = 1'b0;
    send_wt(8'h01); send_wt(8'h02); send_wt(8'h03);
    job_start = 1'b1; @(negedge clk); job_start = 1'b0;
    send_wt(8'h04);
    chk("mid_act_ready", 32'(act_ready), 1);
    chk("mid_n_wf_reset", n_wfr, 1);
    send_act(16'h0777);
    chk("mid_act_valid", 32'(init_act_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_act_ready", 32'(act_ready), 0);
    chk("ar_act_valid", 32'(init_act_valid), 0);
    chk("ar_act_data", 32'(init_act_data), 0);
    chk("ar_wf_data", 32'(wf_data_in), 0);
    chk("ar_weights_ready", 32'(weights_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    run_job(8'h0A, 8'h0B, 8'h0C, 8'h0D, 16'h00AA, 16'h00BB, 1'b0, 2, 32'sd42, 2, lat, rd, rto);
    chk("re_lat", lat, 3);
    chk("re_data", rd, 42);
    chk("re_timeout", 32'(rto), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
